// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//
// Recovers the four digits shown on a multiplexed, active-low 7-segment
// display by snooping its segment and anode buses. Each {an, seg} sample
// must repeat for STABLE_CNT cycles before it is accepted as a digit. Four
// accepted positions form a frame, which is then published on digits.
//
// Parameters
//   STABLE_CNT   consecutive identical samples needed to accept a digit (2..255)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   seg[6:0]     active-low segments, seg[0]=a ... seg[6]=g
//   an[3:0]      active-low digit enables, an[i] selects position i
//   digits[15:0] last complete frame, digit i in digits[4i+3:4i]
//   frame_valid  one-cycle pulse when digits updates
//   dec_err      one-cycle pulse when a stable but undecodable pattern is accepted
//
// Configuration
//   SEG7_HEX_DECODE_EN  when defined, also decodes the hex letters A, b, C, d, E, F.
//                       When undefined, those patterns are undecodable.

module seg7_scan_decoder #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        dec_err
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CNT);

    // Input sample registers
    logic [6:0]       seg_q;
    logic [3:0]       an_q;

    // Stability tracking
    logic [10:0]      prev_q, prev_d;
    logic [7:0]       cnt_q, cnt_d;

    // Frame assembly
    logic [3:0][3:0]  stage_q, stage_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      digits_q, digits_d;
    logic             frame_valid_q, frame_valid_d;
    logic             dec_err_q, dec_err_d;

    // Combinational helpers
    logic             sample_valid;
    logic [1:0]       sample_pos;
    logic [10:0]      sample;
    logic             commit;
    logic             dec_ok;
    logic [3:0]       dec_val;
    logic             frame_xfer;

    assign sample = {an_q, seg_q};

    // A sample is usable only when exactly one position is enabled.
    always_comb begin
        sample_valid = 1'b0;
        sample_pos   = 2'd0;
        case (an_q)
            4'b1110: begin sample_valid = 1'b1; sample_pos = 2'd0; end
            4'b1101: begin sample_valid = 1'b1; sample_pos = 2'd1; end
            4'b1011: begin sample_valid = 1'b1; sample_pos = 2'd2; end
            4'b0111: begin sample_valid = 1'b1; sample_pos = 2'd3; end
            default: begin sample_valid = 1'b0; sample_pos = 2'd0; end
        endcase
    end

    // Active-low segment pattern to digit value.
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (seg_q)
            7'h40:   dec_val = 4'h0;
            7'h79:   dec_val = 4'h1;
            7'h24:   dec_val = 4'h2;
            7'h30:   dec_val = 4'h3;
            7'h19:   dec_val = 4'h4;
            7'h12:   dec_val = 4'h5;
            7'h02:   dec_val = 4'h6;
            7'h78:   dec_val = 4'h7;
            7'h00:   dec_val = 4'h8;
            7'h10:   dec_val = 4'h9;
`ifdef SEG7_HEX_DECODE_EN
            7'h08:   dec_val = 4'hA;
            7'h03:   dec_val = 4'hB;
            7'h46:   dec_val = 4'hC;
            7'h21:   dec_val = 4'hD;
            7'h06:   dec_val = 4'hE;
            7'h0E:   dec_val = 4'hF;
`endif
            default: dec_ok  = 1'b0;
        endcase
    end

    // Stability counter. A zero count means "no run in progress", so the first
    // valid sample after an invalid one always reloads to 1 even if it matches
    // the stale prev_q.
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        if (!sample_valid) begin
            cnt_d = 8'd0;
        end else begin
            prev_d = sample;
            if ((sample == prev_q) && (cnt_q != 8'd0)) begin
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd1;
            end
        end
    end

    // Commit only on the transition into StableCnt; the cnt_q check also stops
    // a run saturated at 255 from committing every cycle.
    assign commit = sample_valid && (cnt_d == StableCnt) && (cnt_q != StableCnt);

    assign frame_xfer = (seen_q == 4'hF);

    // Frame assembly. The transfer uses the old staging contents, so a commit
    // landing in the same cycle belongs to the next frame.
    always_comb begin
        stage_d       = stage_q;
        seen_d        = frame_xfer ? 4'h0 : seen_q;
        digits_d      = frame_xfer ? stage_q : digits_q;
        frame_valid_d = frame_xfer;
        dec_err_d     = 1'b0;
        if (commit) begin
            if (dec_ok) begin
                stage_d[sample_pos] = dec_val;
                seen_d[sample_pos]  = 1'b1;
            end else begin
                dec_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= 7'h00;
            an_q          <= 4'h0;
            prev_q        <= 11'h000;
            cnt_q         <= 8'd0;
            stage_q       <= '0;
            seen_q        <= 4'h0;
            digits_q      <= 16'h0000;
            frame_valid_q <= 1'b0;
            dec_err_q     <= 1'b0;
        end else begin
            seg_q         <= seg;
            an_q          <= an;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            frame_valid_q <= frame_valid_d;
            dec_err_q     <= dec_err_d;
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign dec_err     = dec_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Testbench for seg7_scan_decoder: directed scenarios plus randomized scanning,
// with every output compared each cycle against a behavioural model.
// Honours SEG7_HEX_DECODE_EN the same way the design does.

module tb_seg7_scan_decoder;

    localparam int STABLE = 4;

`ifdef SEG7_HEX_DECODE_EN
    localparam int NDEC = 16;
`else
    localparam int NDEC = 10;
`endif

    // Active-low patterns for values 0..F
    localparam logic [6:0] PATS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [15:0] digits;
    logic        frame_valid;
    logic        dec_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    int fv_cnt   = 0;
    int de_cnt   = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .STABLE_CNT (STABLE)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .frame_valid (frame_valid),
        .dec_err     (dec_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < NDEC; i++) begin
            if (PATS[i] == s) return i;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [3:0]  m_an  = 4'h0;
    logic [6:0]  m_seg = 7'h00;
    logic [10:0] m_last = '0;
    int          m_run = 0;
    int          m_stg [4] = '{0, 0, 0, 0};
    bit [3:0]    m_seen = 4'h0;
    logic [15:0] exp_digits = 16'h0;
    logic        exp_fv = 1'b0;
    logic        exp_de = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_an = 4'h0; m_seg = 7'h00; m_last = '0; m_run = 0;
            m_stg = '{0, 0, 0, 0}; m_seen = 4'h0;
            exp_digits = 16'h0; exp_fv = 1'b0; exp_de = 1'b0;
        end else begin
            int pos;
            int v;
            exp_fv = 1'b0;
            exp_de = 1'b0;
            if ($countones(~m_an) == 1) begin
                if (m_run > 0 && {m_an, m_seg} == m_last) m_run++;
                else m_run = 1;
                m_last = {m_an, m_seg};
            end else begin
                m_run = 0;
            end
            if (m_seen == 4'hF) begin
                exp_digits = 16'(m_stg[0] + 16 * m_stg[1] + 256 * m_stg[2] + 4096 * m_stg[3]);
                exp_fv = 1'b1;
                m_seen = 4'h0;
            end
            if (m_run == STABLE) begin
                pos = 0;
                for (int i = 0; i < 4; i++) if (!m_an[i]) pos = i;
                v = decode(m_seg);
                if (v < 0) exp_de = 1'b1;
                else begin
                    m_stg[pos] = v;
                    m_seen[pos] = 1'b1;
                end
            end
            m_an  = an;
            m_seg = seg;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("digits", 32'(digits), 32'(exp_digits));
            check_eq("frame_valid", 32'(frame_valid), 32'(exp_fv));
            check_eq("dec_err", 32'(dec_err), 32'(exp_de));
            if (frame_valid) fv_cnt++;
            if (dec_err) de_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int fv0;
        int de0;
        logic [3:0] one;
        logic [3:0] ra;
        logic [6:0] rs;

        repeat (2) @(posedge clk);
        do_reset();
        chk_en = 1'b1;
        check_eq("reset_digits", 32'(digits), 32'h0);

        // Full frame, one digit per position
        fv0 = fv_cnt;
        drive(4'b1110, 7'h79, STABLE);
        drive(4'b1101, 7'h24, STABLE);
        drive(4'b1011, 7'h30, STABLE);
        drive(4'b0111, 7'h19, STABLE);
        drive(4'hF, 7'h7F, 6);
        check_eq("frame_digits", 32'(digits), 32'h4321);
        check_eq("frame_pulses", 32'(fv_cnt - fv0), 32'd1);

        // Run one sample too short
        do_reset();
        fv0 = fv_cnt; de0 = de_cnt;
        drive(4'b1110, 7'h79, STABLE - 1);
        drive(4'b1101, 7'h7F, STABLE - 1);
        drive(4'hF, 7'h7F, 4);
        drive(4'b1101, 7'h24, STABLE);
        drive(4'b1011, 7'h30, STABLE);
        drive(4'b0111, 7'h19, STABLE);
        drive(4'hF, 7'h7F, 6);
        check_eq("short_run_fv", 32'(fv_cnt - fv0), 32'd0);
        check_eq("short_run_de", 32'(de_cnt - de0), 32'd0);
        check_eq("short_run_digits", 32'(digits), 32'h0);

        // Two enables active at once
        do_reset();
        fv0 = fv_cnt; de0 = de_cnt;
        drive(4'b1100, 7'h40, 10);
        drive(4'hF, 7'h7F, 4);
        check_eq("multi_an_fv", 32'(fv_cnt - fv0), 32'd0);
        check_eq("multi_an_de", 32'(de_cnt - de0), 32'd0);

        // Hex letter A on position 0
        do_reset();
        fv0 = fv_cnt; de0 = de_cnt;
        drive(4'b1110, 7'h08, STABLE);
        drive(4'b1101, 7'h79, STABLE);
        drive(4'b1011, 7'h24, STABLE);
        drive(4'b0111, 7'h30, STABLE);
        drive(4'hF, 7'h7F, 6);
`ifdef SEG7_HEX_DECODE_EN
        check_eq("hex_de", 32'(de_cnt - de0), 32'd0);
        check_eq("hex_fv", 32'(fv_cnt - fv0), 32'd1);
        check_eq("hex_digits", 32'(digits), 32'h321A);
`else
        check_eq("hex_de", 32'(de_cnt - de0), 32'd1);
        check_eq("hex_fv", 32'(fv_cnt - fv0), 32'd0);
        check_eq("hex_digits", 32'(digits), 32'h0);
`endif

        // Reset discards a partial frame
        do_reset();
        fv0 = fv_cnt;
        drive(4'b1110, 7'h79, STABLE);
        drive(4'b1101, 7'h24, STABLE);
        drive(4'b1011, 7'h30, STABLE);
        drive(4'hF, 7'h7F, 2);
        do_reset();
        drive(4'b0111, 7'h19, STABLE);
        drive(4'hF, 7'h7F, 6);
        check_eq("partial_reset_fv", 32'(fv_cnt - fv0), 32'd0);
        check_eq("partial_reset_digits", 32'(digits), 32'h0);

        // Overwrite of a slot before the frame completes
        do_reset();
        fv0 = fv_cnt;
        drive(4'b1110, 7'h40, STABLE);
        drive(4'b1110, 7'h12, STABLE);
        drive(4'b1101, 7'h79, STABLE);
        drive(4'b1011, 7'h24, STABLE);
        drive(4'b0111, 7'h30, STABLE);
        drive(4'hF, 7'h7F, 6);
        check_eq("overwrite_fv", 32'(fv_cnt - fv0), 32'd1);
        check_eq("overwrite_digit0", 32'(digits[3:0]), 32'h5);
        check_eq("overwrite_digits", 32'(digits), 32'h3215);

        // Randomized scanning, checked cycle by cycle against the model
        one = 4'b0001;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 40) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) != 0) ra = ~(one << $urandom_range(0, 3));
                else ra = 4'($urandom);
                if ($urandom_range(0, 4) != 0) rs = PATS[$urandom_range(0, 15)];
                else rs = 7'($urandom);
                drive(ra, rs, $urandom_range(1, 7));
            end
        end
        drive(4'hF, 7'h7F, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4: consecutive identical samples needed to accept one digit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port seg, input, 7 bits: active-low segment bus, seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g.
REQ-005 SHALL have port an, input, 4 bits: active-low digit enables, an[i] selects display position i.
REQ-006 SHALL have port digits, output, 16 bits: last complete frame, digit i in digits[4i+3:4i].
REQ-007 SHALL have port frame_valid, output, 1 bit: one-cycle pulse when digits updates.
REQ-008 SHALL have port dec_err, output, 1 bit: one-cycle pulse when a stable but undecodable pattern is accepted.

Function
REQ-009 SHALL register seg and an once, giving one cycle of input latency; all further rules apply to the registered sample.
REQ-010 SHALL treat a sample as valid only when exactly one bit of an is 0; otherwise it SHALL clear the stability counter and commit nothing.
REQ-011 SHALL increment a saturating stability counter while valid samples repeat the previous {an,seg}; any change SHALL reload the counter to 1.
REQ-012 SHALL commit exactly once per stable run, in the cycle the counter reaches STABLE_CNT; further identical samples SHALL NOT commit again until the run breaks.
REQ-013 SHALL decode seg as follows (active-low hex): 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9.
REQ-014 SHALL, on a commit with a decodable pattern, write the value into staging slot i and set seen[i]; a repeated commit to the same slot SHALL overwrite it.
REQ-015 SHALL, on a commit with an undecodable pattern, pulse dec_err for one cycle, leave staging and seen[i] unchanged.
REQ-016 SHALL, in the cycle after seen becomes 4'b1111, copy all four staging slots into digits at once, pulse frame_valid, and clear seen.
REQ-017 SHALL accept a commit in the same cycle as the frame transfer; that commit SHALL go to staging and seen for the next frame and SHALL NOT alter digits.
REQ-018 SHALL hold digits constant between frame_valid pulses; arrival order of positions is irrelevant.

Reset
REQ-019 SHALL, while rst=1 at a clock edge, clear the input registers, stability counter, staging slots and seen, set digits=16'h0000, frame_valid=0 and dec_err=0.
REQ-020 SHALL discard any partial frame and any in-progress stable run on reset; after release, a full new STABLE_CNT run is required for the first commit.

Configuration
REQ-021 SHALL, with macro SEG7_HEX_DECODE_EN defined, also decode 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F.
REQ-022 SHALL, without SEG7_HEX_DECODE_EN, treat those six patterns as undecodable per REQ-015.

Verification
REQ-023 SHALL cover: reset, then an=1110 seg=79, an=1101 seg=24, an=1011 seg=30, an=0111 seg=19, each held 4 cycles -> one frame_valid pulse, digits=16'h4321.
REQ-024 SHALL cover: an=1110 seg=79 held 3 cycles, then changed -> no commit, seen stays 0000, no pulses.
REQ-025 SHALL cover: an=1100 (two enables) with seg=40 for 10 cycles -> no commit, counter stays 0.
REQ-026 SHALL cover: an=1110 seg=08 held 4 cycles -> dec_err pulse without SEG7_HEX_DECODE_EN; with it, slot 0 becomes 4'hA and no dec_err.
REQ-027 SHALL cover: three positions committed, then rst=1 for one cycle, then only the fourth position -> no frame_valid, digits stays 16'h0000.
REQ-028 SHALL cover: position 0 committed as seg=40 then as seg=12 before the frame completes, then other positions -> digits[3:0]=4'h5.
